// File: rtl/param_updown_counter.sv
// Synchronous modulo-N up/down counter with a built-in prescaler.
// Every flop is clocked by clk; there is no ripple or derived clock.
// Priority on each edge: clr > load > count step > hold.
// In wrap mode (SATURATE=0) the counter wraps at either range end and raises wrap.
// In saturate mode (SATURATE=1) it holds at a range end and raises sat.
// tc can be used to cascade instances for wider counts.
module param_updown_counter #(
    parameter int WIDTH    = 8,
    parameter int MOD_VAL  = 256,
    parameter int PRESCALE = 1,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] cnt,
    output logic             tc,
    output logic             step,
    output logic             wrap,
    output logic             sat
);

    // Prescaler width; one bit is kept even when PRESCALE=1 so the vector is never empty.
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    // Highest legal count. With MOD_VAL = 2^WIDTH this is all ones.
    localparam logic [WIDTH-1:0] MAX_CNT  = WIDTH'(MOD_VAL - 1);
    localparam logic [WIDTH:0]   MOD_EXT  = (WIDTH + 1)'(MOD_VAL);
    localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1'b1);
    localparam logic [PW-1:0]    PRE_ONE  = PW'(1'b1);

    logic [WIDTH-1:0] cnt_r;
    logic [PW-1:0]    pre_r;
    logic             step_r;
    logic             wrap_r;
    logic             sat_r;

    logic [WIDTH-1:0] cnt_nxt_s;
    logic [PW-1:0]    pre_nxt_s;
    logic             step_nxt_s;
    logic             wrap_nxt_s;
    logic             sat_nxt_s;

    // Clamp a load value to the top of the range.
    // The compare uses one extra bit so that MOD_VAL = 2^WIDTH does not overflow.
    function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] val);
        logic [WIDTH-1:0] res;
        if ({1'b0, val} >= MOD_EXT) begin
            res = MAX_CNT;
        end else begin
            res = val;
        end
        return res;
    endfunction

    // Next-state logic: clear, load, prescaled step with wrap/saturate handling, or hold.
    always_comb begin
        cnt_nxt_s  = cnt_r;
        pre_nxt_s  = pre_r;
        step_nxt_s = 1'b0;
        wrap_nxt_s = 1'b0;
        sat_nxt_s  = sat_r;
        if (clr) begin
            cnt_nxt_s = {WIDTH{1'b0}};
            pre_nxt_s = {PW{1'b0}};
            sat_nxt_s = 1'b0;
        end else if (load) begin
            cnt_nxt_s = clamp_load(load_val);
            pre_nxt_s = {PW{1'b0}};
            sat_nxt_s = 1'b0;
        end else if (en) begin
            if (pre_r == PRE_LAST) begin
                // This enabled cycle completes a prescale interval, so a step occurs.
                pre_nxt_s  = {PW{1'b0}};
                step_nxt_s = 1'b1;
                if (up) begin
                    if (cnt_r != MAX_CNT) begin
                        cnt_nxt_s = cnt_r + CNT_ONE;
                        sat_nxt_s = 1'b0;
                    end else if (SATURATE != 0) begin
                        cnt_nxt_s = cnt_r;
                        sat_nxt_s = 1'b1;
                    end else begin
                        cnt_nxt_s  = {WIDTH{1'b0}};
                        wrap_nxt_s = 1'b1;
                        sat_nxt_s  = 1'b0;
                    end
                end else begin
                    if (cnt_r != {WIDTH{1'b0}}) begin
                        cnt_nxt_s = cnt_r - CNT_ONE;
                        sat_nxt_s = 1'b0;
                    end else if (SATURATE != 0) begin
                        cnt_nxt_s = cnt_r;
                        sat_nxt_s = 1'b1;
                    end else begin
                        cnt_nxt_s  = MAX_CNT;
                        wrap_nxt_s = 1'b1;
                        sat_nxt_s  = 1'b0;
                    end
                end
            end else begin
                // Mid-interval: advance the prescaler and leave the count unchanged.
                pre_nxt_s = pre_r + PRE_ONE;
            end
        end else begin
            // en low freezes both the prescale phase and the count.
            cnt_nxt_s = cnt_r;
            pre_nxt_s = pre_r;
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r  <= {WIDTH{1'b0}};
            pre_r  <= {PW{1'b0}};
            step_r <= 1'b0;
            wrap_r <= 1'b0;
            sat_r  <= 1'b0;
        end else begin
            cnt_r  <= cnt_nxt_s;
            pre_r  <= pre_nxt_s;
            step_r <= step_nxt_s;
            wrap_r <= wrap_nxt_s;
            sat_r  <= sat_nxt_s;
        end
    end

    assign cnt  = cnt_r;
    assign step = step_r;
    assign wrap = wrap_r;
    assign sat  = sat_r;

    // tc depends only on the current count and direction, not on en or the prescaler.
    assign tc = up ? (cnt_r == MAX_CNT) : (cnt_r == {WIDTH{1'b0}});

endmodule

// File: tb/tb_param_updown_counter.sv
// Bench for param_updown_counter.
// Four instances share one input stream, each with different parameters:
//   u0: WIDTH=8, MOD_VAL=256, PRESCALE=1, SATURATE=0
//   u1: WIDTH=4, MOD_VAL=10,  PRESCALE=1, SATURATE=0
//   u2: WIDTH=4, MOD_VAL=10,  PRESCALE=4, SATURATE=0
//   u3: WIDTH=4, MOD_VAL=10,  PRESCALE=1, SATURATE=1
// A behavioural model (plain integers) is compared against every instance each cycle.
// Hand-computed literals pin the model at the boundary cases.
module tb_param_updown_counter;

    logic       clk;
    logic       rst;
    logic       en;
    logic       up;
    logic       clr;
    logic       load;
    logic [7:0] load_val;

    logic [7:0] cnt0;
    logic [3:0] cnt1;
    logic [3:0] cnt2;
    logic [3:0] cnt3;
    logic [3:0] tc_v;
    logic [3:0] step_v;
    logic [3:0] wrap_v;
    logic [3:0] sat_v;

    int checks = 0;
    int errors = 0;

    // Model state, indexed by instance number.
    int m_cnt  [4];
    int m_ph   [4];
    int m_step [4];
    int m_wrap [4];
    int m_sat  [4];

    param_updown_counter #(.WIDTH(8), .MOD_VAL(256), .PRESCALE(1), .SATURATE(0)) u0 (
        .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(load_val), .cnt(cnt0), .tc(tc_v[0]), .step(step_v[0]),
        .wrap(wrap_v[0]), .sat(sat_v[0]));
    param_updown_counter #(.WIDTH(4), .MOD_VAL(10), .PRESCALE(1), .SATURATE(0)) u1 (
        .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(load_val[3:0]), .cnt(cnt1), .tc(tc_v[1]), .step(step_v[1]),
        .wrap(wrap_v[1]), .sat(sat_v[1]));
    param_updown_counter #(.WIDTH(4), .MOD_VAL(10), .PRESCALE(4), .SATURATE(0)) u2 (
        .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(load_val[3:0]), .cnt(cnt2), .tc(tc_v[2]), .step(step_v[2]),
        .wrap(wrap_v[2]), .sat(sat_v[2]));
    param_updown_counter #(.WIDTH(4), .MOD_VAL(10), .PRESCALE(1), .SATURATE(1)) u3 (
        .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
        .load_val(load_val[3:0]), .cnt(cnt3), .tc(tc_v[3]), .step(step_v[3]),
        .wrap(wrap_v[3]), .sat(sat_v[3]));

    function automatic int p_w(int k);
        return (k == 0) ? 8 : 4;
    endfunction
    function automatic int p_mod(int k);
        return (k == 0) ? 256 : 10;
    endfunction
    function automatic int p_pre(int k);
        return (k == 2) ? 4 : 1;
    endfunction
    function automatic int p_sat(int k);
        return (k == 3) ? 1 : 0;
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: count enabled cycles and move the count by one per completed interval.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < 4; k++) begin
                m_cnt[k] = 0; m_ph[k] = 0; m_step[k] = 0; m_wrap[k] = 0; m_sat[k] = 0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                int lv;
                int tgt;
                m_step[k] = 0;
                m_wrap[k] = 0;
                if (clr) begin
                    m_cnt[k] = 0; m_ph[k] = 0; m_sat[k] = 0;
                end else if (load) begin
                    lv = int'(load_val) % (1 << p_w(k));
                    m_cnt[k] = (lv > p_mod(k) - 1) ? p_mod(k) - 1 : lv;
                    m_ph[k] = 0;
                    m_sat[k] = 0;
                end else if (en) begin
                    m_ph[k] = m_ph[k] + 1;
                    if (m_ph[k] == p_pre(k)) begin
                        m_ph[k] = 0;
                        m_step[k] = 1;
                        tgt = up ? m_cnt[k] + 1 : m_cnt[k] - 1;
                        if (tgt >= 0 && tgt < p_mod(k)) begin
                            m_cnt[k] = tgt;
                            m_sat[k] = 0;
                        end else if (p_sat(k) != 0) begin
                            m_sat[k] = 1;
                        end else begin
                            m_cnt[k] = (tgt + p_mod(k)) % p_mod(k);
                            m_wrap[k] = 1;
                        end
                    end
                end
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare every instance against the model.
    task automatic compare_all();
        int a_cnt[4];
        a_cnt[0] = int'(cnt0);
        a_cnt[1] = int'(cnt1);
        a_cnt[2] = int'(cnt2);
        a_cnt[3] = int'(cnt3);
        for (int k = 0; k < 4; k++) begin
            int exp_tc;
            exp_tc = up ? int'(m_cnt[k] == p_mod(k) - 1) : int'(m_cnt[k] == 0);
            check($sformatf("u%0d.cnt", k), a_cnt[k], m_cnt[k]);
            check($sformatf("u%0d.tc", k), int'(tc_v[k]), exp_tc);
            check($sformatf("u%0d.step", k), int'(step_v[k]), m_step[k]);
            check($sformatf("u%0d.wrap", k), int'(wrap_v[k]), m_wrap[k]);
            check($sformatf("u%0d.sat", k), int'(sat_v[k]), m_sat[k]);
        end
    endtask

    // One clock: let the edge happen, then compare on the falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        rst = 1'b0; en = 1'b0; up = 1'b1; clr = 1'b0; load = 1'b0; load_val = 8'd0;
        @(negedge clk);
        compare_all();
        check("lit_reset_cnt0", int'(cnt0), 0);
        rst = 1'b1;

        // 260 upward steps from 0 on the mod-256 instance.
        en = 1'b1; up = 1'b1;
        for (int i = 1; i <= 260; i++) begin
            tick();
            if (i == 255) begin
                check("lit_t1_cnt255", int'(cnt0), 255);
                check("lit_t1_tc", int'(tc_v[0]), 1);
                check("lit_t1_nowrap", int'(wrap_v[0]), 0);
            end
            if (i == 256) begin
                check("lit_t1_wrapcnt", int'(cnt0), 0);
                check("lit_t1_wrap", int'(wrap_v[0]), 1);
            end
            if (i == 257) check("lit_t1_wrapoff", int'(wrap_v[0]), 0);
        end
        check("lit_t1_end", int'(cnt0), 4);

        // Count down through zero on the mod-10 wrapping instance.
        load = 1'b1; load_val = 8'd2;
        tick();
        check("lit_t2_load", int'(cnt1), 2);
        load = 1'b0; up = 1'b0;
        tick(); check("lit_t2_c1", int'(cnt1), 1);
        tick(); check("lit_t2_c0", int'(cnt1), 0); check("lit_t2_tc", int'(tc_v[1]), 1);
        tick(); check("lit_t2_c9", int'(cnt1), 9); check("lit_t2_wrap", int'(wrap_v[1]), 1);
        tick(); check("lit_t2_c8", int'(cnt1), 8); check("lit_t2_wrapoff", int'(wrap_v[1]), 0);

        // Prescale-by-4 with an en gap in the middle of an interval.
        clr = 1'b1;
        tick();
        clr = 1'b0; en = 1'b1; up = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            if (i == 3) check("lit_t3_pre3", int'(cnt2), 0);
            if (i == 4) begin
                check("lit_t3_step_cnt", int'(cnt2), 1);
                check("lit_t3_step", int'(step_v[2]), 1);
            end
            if (i == 5) check("lit_t3_stepoff", int'(step_v[2]), 0);
        end
        en = 1'b0;
        repeat (3) tick();
        check("lit_t3_frozen", int'(cnt2), 1);
        en = 1'b1;
        tick(); check("lit_t3_resume1", int'(cnt2), 1);
        tick(); check("lit_t3_resume2", int'(cnt2), 2); check("lit_t3_resume_step", int'(step_v[2]), 1);

        // Saturation at the top, then a direction reversal.
        load = 1'b1; load_val = 8'd8;
        tick();
        load = 1'b0; up = 1'b1;
        tick(); check("lit_t4_c9", int'(cnt3), 9); check("lit_t4_nosat", int'(sat_v[3]), 0);
        tick(); check("lit_t4_hold", int'(cnt3), 9); check("lit_t4_sat", int'(sat_v[3]), 1);
        check("lit_t4_nowrap", int'(wrap_v[3]), 0); check("lit_t4_step", int'(step_v[3]), 1);
        tick(); check("lit_t4_hold2", int'(cnt3), 9); check("lit_t4_sat2", int'(sat_v[3]), 1);
        up = 1'b0;
        tick(); check("lit_t4_down", int'(cnt3), 8); check("lit_t4_satoff", int'(sat_v[3]), 0);

        // Load clamping, and clr taking priority over load.
        load = 1'b1; load_val = 8'd15;
        tick(); check("lit_t5_clamp", int'(cnt1), 9); check("lit_t5_noclamp", int'(cnt0), 15);
        clr = 1'b1; load_val = 8'd5;
        tick(); check("lit_t5_clr", int'(cnt1), 0); check("lit_t5_clr2", int'(cnt2), 0);
        clr = 1'b0; load = 1'b0; en = 1'b1; up = 1'b1;

        // 30 enabled cycles leave u2 at cnt=7 with prescale phase 2; then reset asynchronously.
        repeat (30) tick();
        check("lit_t6_pre_rst", int'(cnt2), 7);
        #2 rst = 1'b0;
        #1;
        check("lit_t6_cnt", int'(cnt2), 0);
        check("lit_t6_step", int'(step_v[2]), 0);
        check("lit_t6_cnt0", int'(cnt0), 0);
        compare_all();
        #1 rst = 1'b1;
        tick(); check("lit_t6_first", int'(cnt0), 1);
        tick();
        tick(); check("lit_t6_pre3", int'(cnt2), 0);
        tick(); check("lit_t6_full", int'(cnt2), 1); check("lit_t6_fstep", int'(step_v[2]), 1);

        // Randomized traffic with occasional mid-cycle resets.
        for (int i = 0; i < 3000; i++) begin
            en = ($urandom % 4) != 0;
            if (($urandom % 16) == 0) up = ~up;
            clr = ($urandom % 40) == 0;
            load = ($urandom % 20) == 0;
            load_val = 8'($urandom);
            if (($urandom % 200) == 0) begin
                #2 rst = 1'b0;
                #1 compare_all();
                #1 rst = 1'b1;
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
